// File: rtl/memlibc_mbist_pkg.sv
// -----------------------------------------------------------------------------
// memlibc_mbist_pkg
// Shared definitions for the March C- MBIST controller:
//   state_e      - controller FSM states
//   M0..M5       - march element numbers
//   elem_attr_t  - per-element direction / operation table entry
//   elem_down()  - direction table (1 = descending addresses)
//   elem_attr()  - full per-element table lookup
// March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0);
//           M3 down(r0,w1); M4 down(r1,w0); M5 down(r0)
// -----------------------------------------------------------------------------
package memlibc_mbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    typedef struct packed {
        logic down;   // address order: 1 = high to low
        logic rd;     // element contains a read
        logic wr;     // element contains a write
        logic rval;   // background expected by the read
        logic wval;   // background written
    } elem_attr_t;

    function automatic logic elem_down(input logic [2:0] e);
        return (e == M3) || (e == M4) || (e == M5);
    endfunction

    function automatic elem_attr_t elem_attr(input logic [2:0] e);
        elem_attr_t a;
        a = '0;
        a.down = elem_down(e);
        case (e)
            M0: begin a.rd = 1'b0; a.wr = 1'b1; a.rval = 1'b0; a.wval = 1'b0; end
            M1: begin a.rd = 1'b1; a.wr = 1'b1; a.rval = 1'b0; a.wval = 1'b1; end
            M2: begin a.rd = 1'b1; a.wr = 1'b1; a.rval = 1'b1; a.wval = 1'b0; end
            M3: begin a.rd = 1'b1; a.wr = 1'b1; a.rval = 1'b0; a.wval = 1'b1; end
            M4: begin a.rd = 1'b1; a.wr = 1'b1; a.rval = 1'b1; a.wval = 1'b0; end
            M5: begin a.rd = 1'b1; a.wr = 1'b0; a.rval = 1'b0; a.wval = 1'b0; end
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/memlibc_mbist_addr_cnt.sv
// -----------------------------------------------------------------------------
// memlibc_mbist_addr_cnt
// Up/down address counter for the march sequencer.
//   clk, rst_n  - clock, asynchronous active-low reset
//   init        - load address 0 (start of M0, an ascending element)
//   step        - advance one address in the current direction
//   down        - direction of the current element
//   next_down   - direction of the following element; selects the reload
//                 value on wrap so the next element starts without a gap
//   addr        - current address
//   wrap        - current address is the last one for this direction
// -----------------------------------------------------------------------------
module memlibc_mbist_addr_cnt #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              step,
    input  logic              down,
    input  logic              next_down,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    assign wrap = down ? (addr == '0) : (addr == ADDR_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (init) begin
            addr <= '0;
        end else if (step) begin
            if (wrap)
                addr <= next_down ? ADDR_MAX : '0;
            else if (down)
                addr <= addr - ADDR_ONE;
            else
                addr <= addr + ADDR_ONE;
        end
    end

endmodule

// File: rtl/memlibc_mbist_march_ctrl.sv
// -----------------------------------------------------------------------------
// memlibc_mbist_march_ctrl
// March C- memory BIST controller driving a memory through collar muxes.
//   bist_clk, bist_rst_n  - clock, asynchronous active-low reset
//   start                 - one-cycle pulse, accepted in IDLE or DONE only
//   test_sel              - 1 while BIST owns the memory (RUN and DRAIN)
//   mem_addr, mem_wdata   - memory address / background write data
//   mem_we, mem_re        - write / read strobes
//   mem_rdata             - read data
//   busy, done            - run in progress / run finished (sticky)
//   fail                  - sticky mismatch flag
//   fail_addr, fail_elem  - address and march element of the first mismatch
//   state_dbg             - current FSM state
// Memory protocol: each RUN cycle carries exactly one operation, either
// mem_we or mem_re (never both); a read returns mem_rdata one cycle after
// the cycle in which mem_re was high, with no back-pressure.
// -----------------------------------------------------------------------------
module memlibc_mbist_march_ctrl
    import memlibc_mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              bist_clk,
    input  logic              bist_rst_n,
    input  logic              start,
    output logic              test_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output state_e            state_dbg
);

    state_e            state, state_nx;
    logic [2:0]        elem;
    logic              phase;       // 0 = read slot, 1 = write slot of r,w elements
    elem_attr_t        attr;
    logic              in_run;
    logic              rd_op, wr_op;
    logic              step;
    logic              elem_end;
    logic              accept;
    logic [ADDR_W-1:0] addr;
    logic              wrap;

    // Registered copy of the read expectation, compared when data returns.
    logic              cmp_vld;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic [2:0]        cmp_elem;

    assign attr     = elem_attr(elem);
    assign in_run   = (state == RUN);
    assign rd_op    = in_run && attr.rd && !phase;
    assign wr_op    = in_run && attr.wr && (phase || !attr.rd);
    // Two-operation elements advance the address only after the write slot.
    assign step     = in_run && (phase || !(attr.rd && attr.wr));
    assign elem_end = step && wrap;
    assign accept   = start && ((state == IDLE) || (state == DONE));

    memlibc_mbist_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk       (bist_clk),
        .rst_n     (bist_rst_n),
        .init      (accept),
        .step      (step),
        .down      (attr.down),
        .next_down (elem_down(elem + 3'd1)),
        .addr      (addr),
        .wrap      (wrap)
    );

    // FSM state register
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (elem_end && (elem == M5)) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Element / slot sequencing
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            elem  <= M0;
            phase <= 1'b0;
        end else if (accept) begin
            elem  <= M0;
            phase <= 1'b0;
        end else begin
            if (elem_end && (elem != M5))
                elem <= elem + 3'd1;
            if (in_run && attr.rd && attr.wr)
                phase <= ~phase;
            else
                phase <= 1'b0;
        end
    end

    // Compare pipeline and sticky first-failure capture
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            cmp_vld   <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
            cmp_elem  <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            cmp_vld  <= rd_op;
            cmp_exp  <= {DATA_W{attr.rval}};
            cmp_addr <= addr;
            cmp_elem <= elem;
            if (accept) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
            end else if (cmp_vld && (mem_rdata != cmp_exp) && !fail) begin
                fail      <= 1'b1;
                fail_addr <= cmp_addr;
                fail_elem <= cmp_elem;
            end
        end
    end

    assign busy      = (state == RUN) || (state == DRAIN);
    assign test_sel  = busy;
    assign done      = (state == DONE);
    assign mem_re    = rd_op;
    assign mem_we    = wr_op;
    assign mem_addr  = in_run ? addr : '0;
    assign mem_wdata = wr_op ? {DATA_W{attr.wval}} : '0;
    assign state_dbg = state;

endmodule

// File: doc/memlibc_mbist_march_ctrl.md
MEMLIBC_MBIST_MARCH_CTRL -- requirements
Module: memlibc_mbist_march_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, memory address width (depth = 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port bist_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port bist_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; starts a run when idle.
REQ-006 SHALL have port test_sel  output  1  select driven to the collar mux2 cells (1 = BIST drives memory).
REQ-007 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-008 SHALL have port mem_wdata  output  DATA_W  write data (all-0 or all-1 background).
REQ-009 SHALL have ports mem_we and mem_re  output  1 each  write and read strobes, never both high.
REQ-010 SHALL have port mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_re.
REQ-011 SHALL have ports busy and done  output  1 each  run in progress; run finished (sticky until next start).
REQ-012 SHALL have port fail  output  1  sticky mismatch flag.
REQ-013 SHALL have ports fail_addr (ADDR_W) and fail_elem (3)  output  address and march element of first mismatch.

Function
REQ-014 SHALL execute March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 down(r0); elements numbered 0..5.
REQ-015 SHALL use FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after last M5 read; DRAIN->DONE after 1 cycle; DONE->RUN on start.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL issue one operation per cycle: w-only element 1 cycle/address; r,w elements read cycle then write cycle at the same address; M5 1 cycle/address.
REQ-018 SHALL count addresses 0..2**ADDR_W-1 for up elements and 2**ADDR_W-1..0 for down elements, advancing the element on wrap with no idle cycle between elements.
REQ-019 SHALL compare mem_rdata with the expected value (all-0 or all-1) in the cycle after each read, using a 1-stage registered copy of expected data, address and element.
REQ-020 SHALL on the first mismatch set fail and capture fail_addr/fail_elem; later mismatches SHALL NOT overwrite them; run continues to completion.
REQ-021 SHALL hold test_sel and busy high from the cycle after start through DRAIN inclusive; low in IDLE and DONE.
REQ-022 SHALL drive mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0 outside RUN.
REQ-023 SHALL take exactly 10*2**ADDR_W + 1 cycles from the first RUN cycle to done rising (640 + 1 for the default).
REQ-024 SHALL clear fail, fail_addr, fail_elem and done on an accepted start.

Reset
REQ-025 SHALL on bist_rst_n low asynchronously enter IDLE and force all outputs to 0, including mid-run; comparison pipeline is discarded.
REQ-026 SHALL release reset synchronously to bist_clk (deassertion synchronized externally); first accepted start is allowed the cycle after release.

Structure
REQ-027 SHALL place the FSM state enum, the element-number constants (M0..M5) and per-element direction/op tables in package memlibc_mbist_pkg.
REQ-028 SHALL implement the address counter (up/down, wrap flag) as sub-module memlibc_mbist_addr_cnt; everything else in the top.
REQ-029 SHALL contain no latches and no combinational path from mem_rdata to any output.

Verification
REQ-030 Fault-free model, ADDR_W=6: start -> done after 641 cycles, fail=0, test_sel high 641 cycles.
REQ-031 Stuck-at-1 bit 3 at address 0x15 -> fail=1, fail_addr=0x15, fail_elem=1.
REQ-032 Two faults (0x02 in M2, 0x30 in M1) -> fail_addr=0x30, fail_elem=1 (first occurrence kept).
REQ-033 bist_rst_n asserted at cycle 300 of run -> outputs 0 immediately; new start -> clean 641-cycle pass.
REQ-034 start pulsed during RUN -> ignored, done still at cycle 641; start in DONE -> fail/done cleared, new run.
REQ-035 Address sequence check: M3 first access address 0x3F read, last M5 access address 0x00; mem_we and mem_re never both high.
